// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with an optional skid entry and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_width
        $error("pipe_stage_reg: DATA_W=%0d outside 1..1024", DATA_W);
    end
    if (SKID != 0 && SKID != 1) begin : g_bad_skid
        $error("pipe_stage_reg: SKID=%0d must be 0 or 1", SKID);
    end

    logic [1:0]        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_main, w_main_nxt;
    logic [DATA_W-1:0] r_skid, w_skid_nxt;
    logic              w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            if (CLEAR_DATA != 0) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (out_ready) begin
                        if (in_valid) w_main_nxt = in_data;
                        else          w_state_nxt = ST_EMPTY;
                    end else if (in_valid && SKID != 0) begin
                        // consumer stalled: park the beat in the skid entry
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = in_data;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    if (SKID != 0) begin : g_skid_ready
        // registered ready cuts the combinational stall path back to the producer
        logic r_in_ready;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_in_ready <= 1'b1;
            else     r_in_ready <= (w_state_nxt != ST_TWO);
        end
        assign w_in_ready = r_in_ready;
    end else begin : g_comb_ready
        assign w_in_ready = (r_state == ST_EMPTY) | out_ready;
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt, r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!out_valid && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in parallel, checked by a FIFO reference model,
// a directed vector table, hand-written corner sequences and a randomized run.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int N  = 3;   // 0: SKID=1 CLEAR=1, 1: SKID=0 CLEAR=1, 2: SKID=1 CLEAR=0

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          ir [N];
    logic          ov [N];
    logic [DW-1:0] od [N];
    logic [1:0]    occ[N];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   sc [N];
    logic [31:0]   bc [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipe_stage_reg #(
            .DATA_W(DW), .SKID((g == 1) ? 0 : 1), .CLEAR_DATA((g == 2) ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .occupancy(occ[g])
`ifdef PIPE_STAGE_PERF_EN
            , .stall_cnt(sc[g]), .bubble_cnt(bc[g])
`endif
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of capacity 1 or 2 plus the last shown payload.
    logic [DW-1:0] mbuf [N][2];
    int            mcnt [N];
    logic [DW-1:0] mshow[N];
    logic [31:0]   mstall[N];
    logic [31:0]   mbub [N];

    function automatic bit skid_of(int i); return i != 1; endfunction
    function automatic bit clr_of(int i);  return i != 2; endfunction

    function automatic bit m_ready(int i);
        if (skid_of(i)) return mcnt[i] < 2;
        return (mcnt[i] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0; mshow[i] = '0; mstall[i] = '0; mbub[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit rdy;
            bit pop;
            bit push;
            if (mcnt[i] > 0 && !out_ready && mstall[i] != 32'hFFFF_FFFF) mstall[i]++;
            if (mcnt[i] == 0 && mbub[i] != 32'hFFFF_FFFF) mbub[i]++;
            if (flush) begin
                mcnt[i] = 0;
                if (clr_of(i)) mshow[i] = '0;
            end else begin
                rdy  = m_ready(i);
                pop  = (mcnt[i] > 0) && out_ready;
                push = in_valid && rdy;
                if (pop) begin
                    mbuf[i][0] = mbuf[i][1];
                    mcnt[i]--;
                end
                if (push) begin
                    mbuf[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                end
                if (mcnt[i] > 0) mshow[i] = mbuf[i][0];
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.u%0d.out_valid", tag, i), 32'(ov[i]), 32'(mcnt[i] > 0));
            chk($sformatf("%s.u%0d.out_data", tag, i), od[i], mshow[i]);
            chk($sformatf("%s.u%0d.occupancy", tag, i), 32'(occ[i]), 32'(mcnt[i]));
            chk($sformatf("%s.u%0d.in_ready", tag, i), 32'(ir[i]), 32'(m_ready(i)));
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("%s.u%0d.stall_cnt", tag, i), sc[i], mstall[i]);
            chk($sformatf("%s.u%0d.bubble_cnt", tag, i), bc[i], mbub[i]);
`endif
        end
    endtask

    // Inputs are driven at posedge+1; check settles at +2, then one clock edge is taken.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          fl, iv;
        logic [31:0] id;
        bit          ordy;
        bit          e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        bit          e_ir;
    } vec_t;

    function automatic vec_t mk(bit fl, bit iv, logic [31:0] id, bit ordy,
                                bit e_ov, logic [31:0] e_od, logic [1:0] e_occ, bit e_ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        // expectations are for the SKID=1 CLEAR_DATA=1 instance, sampled after each edge
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(0, 1, 32'h11 + k, 1, 1, 32'h11 + k, 2'd1, 1);
        tbl[8]  = mk(0, 0, 32'h0,    1, 0, 32'h18, 2'd0, 1);
        tbl[9]  = mk(0, 1, 32'hA,    0, 1, 32'hA,  2'd1, 1);
        tbl[10] = mk(0, 1, 32'hB,    0, 1, 32'hA,  2'd2, 0);
        tbl[11] = mk(0, 1, 32'hC,    0, 1, 32'hA,  2'd2, 0);
        tbl[12] = mk(0, 1, 32'hC,    1, 1, 32'hB,  2'd1, 1);
        tbl[13] = mk(0, 1, 32'hC,    1, 1, 32'hC,  2'd1, 1);
        tbl[14] = mk(0, 0, 32'h0,    1, 0, 32'hC,  2'd0, 1);
        tbl[15] = mk(0, 1, 32'hD1,   0, 1, 32'hD1, 2'd1, 1);
        tbl[16] = mk(0, 1, 32'hD2,   0, 1, 32'hD1, 2'd2, 0);
        tbl[17] = mk(1, 1, 32'hDEAD, 0, 0, 32'h0,  2'd0, 1);
        tbl[18] = mk(0, 0, 32'h0,    1, 0, 32'h0,  2'd0, 1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        for (int k = 0; k < 19; k++) begin
            flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
            tick($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.out_valid", k), 32'(ov[0]), 32'(tbl[k].e_ov));
            chk($sformatf("vec%0d.out_data", k), od[0], tbl[k].e_od);
            chk($sformatf("vec%0d.occupancy", k), 32'(occ[0]), 32'(tbl[k].e_occ));
            chk($sformatf("vec%0d.in_ready", k), 32'(ir[0]), 32'(tbl[k].e_ir));
        end
        flush = 1'b0;
        chk("nc_flush_keep", od[2], 32'hD1);

        // SKID=0: combinational ready follows out_ready within the cycle
        in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b0;
        tick("s0_fill");
        in_valid = 1'b0;
        #1 chk("s0_full_ir", 32'(ir[1]), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
        #1 chk("s0_comb_ir", 32'(ir[1]), 32'd1);
        tick("s0_b2b");
        chk("s0_data5", od[1], 32'h5);
        chk("s0_valid5", 32'(ov[1]), 32'd1);

        // asynchronous reset while the skid instance holds two beats
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hE1;
        tick("ar_fill1");
        in_data = 32'hE2;
        tick("ar_fill2");
        chk("ar_occ2", 32'(occ[0]), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(ov[0]), 32'd0);
        chk("ar_out_data", od[0], 32'd0);
        chk("ar_occupancy", 32'(occ[0]), 32'd0);
        model_reset();
        check_all("ar_all");
        in_valid = 1'b0; in_data = '0;
        #2 rst = 1'b0;

        // idle, then a stalled full stage, then a flush with the consumer ready
        tick("perf_idle1");
        tick("perf_idle2");
        in_valid = 1'b1; in_data = 32'h77;
        tick("perf_load");
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick($sformatf("perf_stall%0d", k));
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_bubble3", bc[0], 32'd3);
        chk("perf_stall5", sc[0], 32'd5);
`endif
        flush = 1'b1; out_ready = 1'b1;
        tick("perf_flush");
        flush = 1'b0;
        chk("perf_flush_empty", 32'(ov[0]), 32'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_bubble_kept", bc[0], 32'd3);
        chk("perf_stall_kept", sc[0], 32'd5);
`endif

        for (int k = 0; k < 3000; k++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            tick("rand");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick("final");
        check_all("final_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline stage register, the general-purpose replacement for the fixed per-stage registers (IF/ID/EXE/MEM/WB) between CPU pipeline stages.
- Carries an opaque DATA_W-bit payload (packed stage bundle) using a valid/ready handshake instead of a global write enable.
- Supports synchronous flush and an optional skid entry so in_ready is registered, breaking the backward stall path.
- Sits between any two stages; the producer drives in_*, the consumer drives out_ready.

Parameters:
- DATA_W, 32: payload width in bits; legal range 1..1024.
- SKID, 1: 0 = single register, in_ready combinational; 1 = main register plus skid register, in_ready registered.
- CLEAR_DATA, 1: 1 = reset and flush zero out_data and the skid data; 0 = reset zeroes data, flush clears valid only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries and any in_valid beat in the same cycle.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  stage can accept a beat; a transfer occurs when in_valid & in_ready.
- in_data  in  DATA_W  producer payload.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid & out_ready.
- out_data  out  DATA_W  payload, driven directly from the main register.
- occupancy  out  2  number of held entries: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Reset (async, active-high): state EMPTY; out_valid=0; out_data=0; skid data=0; occupancy=0; in_ready=1 (SKID=1). In SKID=0 mode in_ready evaluates to 1 because the stage is empty.
- Latency: one cycle from an accepted input to out_valid. The stage has no combinational in-to-out data path.
- States:
  - EMPTY: occupancy 0.
  - ONE: main register valid.
  - TWO: main and skid valid; SKID=1 only.
- Priority per cycle: rst > flush > handshake.
- flush=1: next state EMPTY; out_valid=0; occupancy=0; in_ready=1 the next cycle. The in_valid beat in the flush cycle is dropped even if in_ready=1. CLEAR_DATA=1 zeroes main and skid data; CLEAR_DATA=0 leaves data unchanged.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - EMPTY + in_valid -> ONE; main <= in_data.
  - ONE + out_ready + in_valid -> ONE; main <= in_data (back-to-back, full throughput).
  - ONE + out_ready + ~in_valid -> EMPTY.
  - ONE + ~out_ready -> hold; main is unchanged.
- SKID=1 (in_ready registered; equals 1 exactly when next state != TWO):
  - EMPTY + in_valid -> ONE; main <= in_data.
  - ONE + in_valid + out_ready -> ONE; main <= in_data.
  - ONE + in_valid + ~out_ready -> TWO; skid <= in_data; main holds.
  - ONE + ~in_valid + out_ready -> EMPTY.
  - ONE + ~in_valid + ~out_ready -> hold.
  - TWO + out_ready -> ONE; main <= skid. in_ready is 0 in TWO, so no input is accepted.
  - TWO + ~out_ready -> hold.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid are held stable.
- occupancy equals the state encoding: EMPTY=0, ONE=1, TWO=2.
- Reset asserted mid-transfer: state clears immediately and asynchronously; the beat is lost.
- Illegal parameter values (DATA_W<1, SKID not in {0,1}) are rejected at elaboration via $error.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt [31:0]: counts cycles with out_valid & ~out_ready.
  - bubble_cnt [31:0]: counts cycles with ~out_valid.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear only on rst; flush does not clear them.
  - A flush cycle is counted by whichever condition holds before the flush takes effect.
- When undefined, the ports and counters are absent and the behaviour above is unchanged.

Test Plan:
- SKID=1, DATA_W=32, out_ready=1: stream 0x11..0x18 on consecutive cycles -> out_data shows 0x11..0x18 on consecutive cycles one cycle later; in_ready stays 1; occupancy stays 1.
- SKID=1: push 0xA, then 0xB while out_ready=0 -> occupancy=2 and in_ready=0; offered 0xC is not accepted. Raise out_ready -> outputs appear in order 0xA, 0xB, then 0xC.
- SKID=0: out_ready=0 with stage full -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 and data 0x5 -> in_ready=1 combinationally; 0x5 appears on the next cycle.
- CLEAR_DATA=1, occupancy=2: pulse flush together with in_valid=1 and data 0xDEAD -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xDEAD never appears. Repeat with CLEAR_DATA=0 -> out_data retains its old value.
- Assert rst asynchronously mid-cycle while occupancy=2 -> out_valid=0, out_data=0 and occupancy=0 before the next clock edge.
- With PIPE_STAGE_PERF_EN: 3 idle cycles, then hold a full stage for 5 cycles with out_ready=0 -> bubble_cnt=3, stall_cnt=5. A subsequent flush leaves both counters unchanged.
